gol_gen_sched: RTL and testbench

- Generation scheduler for the Game-of-Life engine.
- Decides when the cell array advances one generation: free-run at a divided tick rate, or single-step.
- Handshakes each update with the array, then samples the population from the alive counter after its pipeline latency.
- Keeps the generation count and halts automatically on extinction, a stable population, or generation-counter exhaustion.

---
 rtl/gol_gen_sched_if.sv | 11 +
 rtl/gol_gen_sched.sv | 164 ++++++++++++++++
 tb/tb_gol_gen_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gol_gen_sched_if.sv
// rtl/gol_gen_sched_if.sv - update handshake and population bus between scheduler and cell array
interface gol_gen_sched_if #(
    parameter int POP_W = 12
);
    logic             upd_req;
    logic             upd_ack;
    logic [POP_W-1:0] pop_in;

    modport master (output upd_req, input upd_ack, input pop_in);
    modport slave  (input upd_req, output upd_ack, output pop_in);
endinterface

// File: rtl/gol_gen_sched.sv
// rtl/gol_gen_sched.sv - Game-of-Life generation scheduler with auto-halt detection
module gol_gen_sched #(
    parameter int TICK_DIV   = 25000000,
    parameter int GEN_W      = 16,
    parameter int POP_W      = 12,
    parameter int POP_LAT    = 2,
    parameter int STABLE_LIM = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_i,
    input  logic                 step_req_i,
    input  logic                 clear_i,
    gol_gen_sched_if.master      arr,
    output logic                 busy_o,
    output logic [GEN_W-1:0]     generation_o,
    output logic [POP_W-1:0]     pop_out_o,
    output logic                 halted_o,
    output logic [1:0]           halt_code_o
);
    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SET_W  = (POP_LAT > 2) ? $clog2(POP_LAT) : 1;
    localparam int STB_W  = $clog2(STABLE_LIM + 1);

    localparam logic [TICK_W-1:0] TICK_RLD  = TICK_W'(TICK_DIV - 1);
    localparam logic [SET_W-1:0]  SET_RLD   = SET_W'(POP_LAT - 1);
    localparam logic [STB_W-1:0]  STB_LIMIT = STB_W'(STABLE_LIM);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_REQ    = 3'd2,
        S_SETTLE = 3'd3,
        S_EVAL   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [STB_W-1:0]  stable_q, stable_d;
    logic [POP_W-1:0]  prev_pop_q, prev_pop_d;
    logic [POP_W-1:0]  pop_out_q, pop_out_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic [1:0]        code_q, code_d;

    // State and counter registers; clear takes effect through the next-state logic
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            settle_q   <= '0;
            stable_q   <= '0;
            prev_pop_q <= '0;
            pop_out_q  <= '0;
            gen_q      <= '0;
            code_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            settle_q   <= settle_d;
            stable_q   <= stable_d;
            prev_pop_q <= prev_pop_d;
            pop_out_q  <= pop_out_d;
            gen_q      <= gen_d;
            code_q     <= code_d;
        end
    end

    // Next-state, counters and halt decision; clear overrides every state
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        settle_d   = settle_q;
        stable_d   = stable_q;
        prev_pop_d = prev_pop_q;
        pop_out_d  = pop_out_q;
        gen_d      = gen_q;
        code_d     = code_q;

        if (clear_i) begin
            state_d    = S_IDLE;
            tick_d     = '0;
            settle_d   = '0;
            stable_d   = '0;
            prev_pop_d = '0;
            pop_out_d  = '0;
            gen_d      = '0;
            code_d     = 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        state_d = S_WAIT;
                        tick_d  = TICK_RLD;
                    end else if (step_req_i) begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (!run_i) begin
                        state_d = S_IDLE;
                    end else if (tick_q == '0) begin
                        state_d = S_REQ;
                    end else begin
                        tick_d = tick_q - 1'b1;
                    end
                end
                S_REQ: begin
                    // run is deliberately not checked: an issued request always completes
                    if (arr.upd_ack) begin
                        gen_d    = gen_q + 1'b1;
                        settle_d = SET_RLD;
                        state_d  = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = S_EVAL;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                S_EVAL: begin
                    pop_out_d  = arr.pop_in;
                    prev_pop_d = arr.pop_in;
                    if (arr.pop_in == prev_pop_q) begin
                        stable_d = (stable_q == STB_LIMIT) ? stable_q : stable_q + 1'b1;
                    end else begin
                        stable_d = '0;
                    end
                    if (arr.pop_in == '0) begin
                        state_d = S_HALT;
                        code_d  = 2'b01;
                    end else if (stable_d == STB_LIMIT) begin
                        state_d = S_HALT;
                        code_d  = 2'b10;
                    end else if (&gen_q) begin
                        state_d = S_HALT;
                        code_d  = 2'b11;
                    end else if (run_i) begin
                        state_d = S_WAIT;
                        tick_d  = TICK_RLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign arr.upd_req  = (state_q == S_REQ);
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted_o     = (state_q == S_HALT);
    assign generation_o = gen_q;
    assign pop_out_o    = pop_out_q;
    assign halt_code_o  = code_q;
endmodule

// File: tb/tb_gol_gen_sched.sv
// tb/tb_gol_gen_sched.sv - directed self-checking bench for gol_gen_sched
module tb_gol_gen_sched;
    logic        clk;
    logic        rst;
    logic        run;
    logic        step_req;
    logic        clear;
    logic        busy;
    logic [2:0]  generation;
    logic [11:0] pop_out;
    logic        halted;
    logic [1:0]  halt_code;

    int checks   = 0;
    int failures = 0;

    gol_gen_sched_if #(.POP_W(12)) arr_if ();

    gol_gen_sched #(
        .TICK_DIV(4), .GEN_W(3), .POP_W(12), .POP_LAT(2), .STABLE_LIM(3)
    ) dut (
        .clk(clk), .rst(rst), .run_i(run), .step_req_i(step_req), .clear_i(clear),
        .arr(arr_if.master), .busy_o(busy), .generation_o(generation),
        .pop_out_o(pop_out), .halted_o(halted), .halt_code_o(halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell-array model
    logic        ack_en = 1'b0;
    int          ack_dly = 1;
    logic        man_ack = 1'b0;
    logic        use_seq = 1'b0;
    logic [11:0] pop_val = '0;
    logic [11:0] pop_seq [0:7];
    logic [11:0] seq_cur = '0;
    int          pop_idx = 0;
    int          cnt = 0;
    logic        ack_r = 1'b0;
    logic        prev_req = 1'b0;
    int          req_rises = 0;

    always begin
        @(negedge clk);
        #1;
        if (arr_if.upd_req === 1'b1 && prev_req !== 1'b1) req_rises++;
        prev_req = arr_if.upd_req;
        if (man_ack) begin
            ack_r = 1'b1;
        end else if (ack_r) begin
            ack_r = 1'b0;
        end else if (ack_en && arr_if.upd_req === 1'b1) begin
            cnt++;
            if (cnt >= ack_dly) begin
                ack_r = 1'b1;
                cnt   = 0;
                if (use_seq) begin
                    seq_cur = pop_seq[pop_idx];
                    pop_idx++;
                end
            end
        end else begin
            cnt = 0;
        end
        if (!use_seq) pop_idx = 0;
        arr_if.upd_ack = ack_r;
        arr_if.pop_in  = use_seq ? seq_cur : pop_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 400 && halted !== 1'b1; i++) @(negedge clk);
    endtask

    int base;

    initial begin
        rst = 1'b1; run = 1'b0; step_req = 1'b0; clear = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_upd_req", arr_if.upd_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gen", generation, 0);
        chk("rst_pop_out", pop_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_code", halt_code, 0);

        // Free-run: TICK_DIV=4, ack 3 cycles after request, pop 5
        pop_val = 12'd5; ack_en = 1'b1; ack_dly = 3;
        run = 1'b1;
        tick(4);
        chk("run_req_early", arr_if.upd_req, 0);
        chk("run_busy", busy, 1);
        tick(1);
        chk("run_req_rise", arr_if.upd_req, 1);
        tick(2);
        chk("run_gen_before_ack", generation, 0);
        tick(1);
        chk("run_gen_after_ack", generation, 1);
        chk("run_req_drop", arr_if.upd_req, 0);
        tick(2);
        chk("run_pop_before_eval", pop_out, 0);
        tick(1);
        chk("run_pop_after_eval", pop_out, 5);
        tick(3);
        chk("run_req2_early", arr_if.upd_req, 0);
        tick(1);
        chk("run_req2_rise", arr_if.upd_req, 1);
        run = 1'b0;
        tick(6);
        chk("run_stop_busy", busy, 0);
        chk("run_stop_gen", generation, 2);
        pulse_clear();
        chk("clear_gen", generation, 0);
        chk("clear_pop", pop_out, 0);

        // Single step with a second step issued during SETTLE
        pop_val = 12'd7; ack_dly = 2;
        base = req_rises;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        chk("step_req_up", arr_if.upd_req, 1);
        tick(2);
        chk("step_gen", generation, 1);
        chk("step_busy_settle", busy, 1);
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(2);
        chk("step_pop", pop_out, 7);
        chk("step_idle", busy, 0);
        tick(6);
        chk("step_one_req", req_rises - base, 1);
        pulse_clear();

        // Extinction
        pop_val = 12'd0; ack_dly = 1;
        base = req_rises;
        run = 1'b1;
        wait_halt();
        chk("ext_halted", halted, 1);
        chk("ext_code", halt_code, 1);
        chk("ext_gen", generation, 1);
        chk("ext_busy", busy, 0);
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(10);
        chk("ext_no_req", req_rises - base, 1);
        chk("ext_hold", halted, 1);
        run = 1'b0;
        pulse_clear();
        chk("ext_clr_halted", halted, 0);
        chk("ext_clr_code", halt_code, 0);
        chk("ext_clr_gen", generation, 0);

        // Stable population
        pop_val = 12'd9;
        run = 1'b1;
        wait_halt();
        chk("stb_code", halt_code, 2);
        chk("stb_gen", generation, 4);
        chk("stb_pop", pop_out, 9);
        run = 1'b0;
        pulse_clear();

        // Population change resets the stable count
        pop_seq[0] = 12'd9; pop_seq[1] = 12'd9; pop_seq[2] = 12'd5; pop_seq[3] = 12'd5;
        pop_seq[4] = 12'd5; pop_seq[5] = 12'd5; pop_seq[6] = 12'd5; pop_seq[7] = 12'd5;
        use_seq = 1'b1;
        run = 1'b1;
        wait_halt();
        chk("stb2_code", halt_code, 2);
        chk("stb2_gen", generation, 6);
        run = 1'b0;
        use_seq = 1'b0;
        pulse_clear();
        tick(1);

        // Generation counter exhaustion
        pop_seq[0] = 12'd4; pop_seq[1] = 12'd6; pop_seq[2] = 12'd4; pop_seq[3] = 12'd6;
        pop_seq[4] = 12'd4; pop_seq[5] = 12'd6; pop_seq[6] = 12'd4; pop_seq[7] = 12'd6;
        use_seq = 1'b1;
        run = 1'b1;
        wait_halt();
        chk("ovf_code", halt_code, 3);
        chk("ovf_gen", generation, 7);
        chk("ovf_pop", pop_out, 4);
        run = 1'b0;
        use_seq = 1'b0;
        pulse_clear();

        // Clear during REQ, ack one cycle later is ignored
        ack_en = 1'b0;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        chk("abort_req_up", arr_if.upd_req, 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        chk("abort_gen", generation, 0);
        chk("abort_req", arr_if.upd_req, 0);
        chk("abort_busy", busy, 0);
        tick(4);
        chk("abort_gen_late", generation, 0);

        // Reset while in SETTLE
        pop_val = 12'd3; ack_en = 1'b1; ack_dly = 1;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(6);
        chk("rs_pop_pre", pop_out, 3);
        chk("rs_gen_pre", generation, 1);
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(1);
        chk("rs_gen_settle", generation, 2);
        chk("rs_busy_settle", busy, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rs_gen", generation, 0);
        chk("rs_pop", pop_out, 0);
        chk("rs_busy", busy, 0);
        chk("rs_req", arr_if.upd_req, 0);
        chk("rs_halted", halted, 0);
        chk("rs_code", halt_code, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
